mpy_32_16_ctrl: RTL and testbench

//  Multi-cycle sequencer computing Mpy_32_16(var1,var2) = L_mac(L_mult(hi,var2), mult(lo,var2), 1),
//  hi=var1[31:16], lo=var1[15:0], on the shared L_mult/mult/L_mac units. Requests the shared operator
//  bus via op_req/op_gnt, drives operands one step per cycle and latches results into an accumulator.

---
 rtl/mpy_32_16_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mpy_32_16_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpy_32_16_ctrl.sv
// Sequencer for Mpy_32_16 on a shared L_mult/mult/L_mac operator bus.
// Steps through one operator per granted cycle and accumulates into registered results.
module mpy_32_16_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] var1,
    input  logic [15:0] var2,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf,
    output logic [31:0] out,
    output logic        op_req,
    input  logic        op_gnt,
    output logic [15:0] L_mult_outa,
    output logic [15:0] L_mult_outb,
    input  logic [31:0] L_mult_in,
    input  logic        L_mult_overflow,
    output logic [15:0] mult_outa,
    output logic [15:0] mult_outb,
    input  logic [15:0] mult_in,
    input  logic        mult_overflow,
    output logic [15:0] L_mac_outa,
    output logic [15:0] L_mac_outb,
    output logic [31:0] L_mac_outc,
    input  logic [31:0] L_mac_in,
    input  logic        L_mac_overflow
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_MULT = 3'd2,
        S_MPY  = 3'd3,
        S_MAC  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      v1_q, v1_d;
    logic [15:0]      v2_q, v2_d;
    logic [31:0]      acc_q, acc_d;
    logic [15:0]      prod_q, prod_d;
    logic [31:0]      out_q, out_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             timeout_c;

    // Grant wins over timeout when both happen in the last allowed request cycle.
    assign timeout_c = (state_q == S_REQ) && !op_gnt && (cnt_q == TMO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ: begin
                if (op_gnt)         state_d = S_MULT;
                else if (timeout_c) state_d = S_IDLE;
            end
            S_MULT: if (op_gnt) state_d = S_MPY;
            S_MPY:  if (op_gnt) state_d = S_MAC;
            S_MAC:  if (op_gnt) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q   <= '0;
            v2_q   <= '0;
            acc_q  <= '0;
            prod_q <= '0;
            out_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            acc_q  <= acc_d;
            prod_q <= prod_d;
            out_q  <= out_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Datapath capture: each stage latches its unit result only on a granted cycle.
    always_comb begin
        v1_d   = v1_q;
        v2_d   = v2_q;
        acc_d  = acc_q;
        prod_d = prod_q;
        out_d  = out_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    v1_d  = var1;
                    v2_d  = var2;
                    ovf_d = 1'b0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                err_d = timeout_c;
            end
            S_MULT: begin
                if (op_gnt) begin
                    acc_d = L_mult_in;
                    ovf_d = ovf_q | L_mult_overflow;
                end
            end
            S_MPY: begin
                if (op_gnt) begin
                    prod_d = mult_in;
                    ovf_d  = ovf_q | mult_overflow;
                end
            end
            S_MAC: begin
                if (op_gnt) begin
                    out_d  = L_mac_in;
                    ovf_d  = ovf_q | L_mac_overflow;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Operand buses stay at zero unless this state owns the unit and holds the grant.
    always_comb begin
        busy        = (state_q != S_IDLE);
        op_req      = (state_q == S_REQ) || (state_q == S_MULT) ||
                      (state_q == S_MPY) || (state_q == S_MAC);
        L_mult_outa = '0;
        L_mult_outb = '0;
        mult_outa   = '0;
        mult_outb   = '0;
        L_mac_outa  = '0;
        L_mac_outb  = '0;
        L_mac_outc  = '0;
        if (op_gnt) begin
            case (state_q)
                S_MULT: begin
                    L_mult_outa = v1_q[31:16];
                    L_mult_outb = v2_q;
                end
                S_MPY: begin
                    mult_outa = v1_q[15:0];
                    mult_outb = v2_q;
                end
                S_MAC: begin
                    L_mac_outa = prod_q;
                    L_mac_outb = 16'd1;
                    L_mac_outc = acc_q;
                end
                default: ;
            endcase
        end
    end

    assign done = done_q;
    assign err  = err_q;
    assign ovf  = ovf_q;
    assign out  = out_q;

endmodule

// File: tb/tb_mpy_32_16_ctrl.sv
// Directed bench for mpy_32_16_ctrl with behavioural G.729 basic-op units on the shared bus.
module tb_mpy_32_16_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] var1;
    logic [15:0] var2;
    logic        busy, done, err, ovf;
    logic [31:0] out;
    logic        op_req, op_gnt;
    logic [15:0] L_mult_outa, L_mult_outb;
    logic [31:0] L_mult_in;
    logic        L_mult_overflow;
    logic [15:0] mult_outa, mult_outb;
    logic [15:0] mult_in;
    logic        mult_overflow;
    logic [15:0] L_mac_outa, L_mac_outb;
    logic [31:0] L_mac_outc;
    logic [31:0] L_mac_in;
    logic        L_mac_overflow;

    int checks = 0;
    int errors = 0;

    mpy_32_16_ctrl #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .start(start), .var1(var1), .var2(var2),
        .busy(busy), .done(done), .err(err), .ovf(ovf), .out(out),
        .op_req(op_req), .op_gnt(op_gnt),
        .L_mult_outa(L_mult_outa), .L_mult_outb(L_mult_outb),
        .L_mult_in(L_mult_in), .L_mult_overflow(L_mult_overflow),
        .mult_outa(mult_outa), .mult_outb(mult_outb),
        .mult_in(mult_in), .mult_overflow(mult_overflow),
        .L_mac_outa(L_mac_outa), .L_mac_outb(L_mac_outb), .L_mac_outc(L_mac_outc),
        .L_mac_in(L_mac_in), .L_mac_overflow(L_mac_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Saturating basic operators, results returned as {overflow, value}.
    function automatic logic [32:0] f_lmult(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        if (p == 32'sh4000_0000) return {1'b1, 32'h7FFF_FFFF};
        return {1'b0, 32'(p <<< 1)};
    endfunction

    function automatic logic [16:0] f_mult(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        logic signed [31:0] q;
        p = $signed(a) * $signed(b);
        q = p >>> 15;
        if (q == 32'sd32768) return {1'b1, 16'h7FFF};
        return {1'b0, q[15:0]};
    endfunction

    function automatic logic [32:0] f_lmac(input logic [31:0] c, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [32:0] m;
        logic [32:0] s;
        m = f_lmult(a, b);
        s = {c[31], c} + {m[31], m[31:0]};
        if (s[32] != s[31]) return {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        return {m[32], s[31:0]};
    endfunction

    always_comb begin
        {L_mult_overflow, L_mult_in} = f_lmult(L_mult_outa, L_mult_outb);
        {mult_overflow, mult_in}     = f_mult(mult_outa, mult_outb);
        {L_mac_overflow, L_mac_in}   = f_lmac(L_mac_outc, L_mac_outa, L_mac_outb);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation; t counts edges since start was driven. Grant is low for t in [drop_from, drop_from+drop_len).
    task automatic run_op(input logic [31:0] v1, input logic [15:0] v2,
                          input int drop_from, input int drop_len,
                          output int lat, output int req_cycles, output logic got_err,
                          output logic ovf_t1, output logic [15:0] lm_a_t2,
                          output logic [15:0] ml_a_t3, output logic [31:0] mac_c_t4);
        var1 = v1;
        var2 = v2;
        start = 1'b1;
        op_gnt = 1'b1;
        lat = 0;
        req_cycles = 0;
        got_err = 1'b0;
        ovf_t1 = 1'bx;
        lm_a_t2 = 'x;
        ml_a_t3 = 'x;
        mac_c_t4 = 'x;
        for (int t = 1; t <= 40; t++) begin
            tick();
            start = 1'b0;
            op_gnt = !(t >= drop_from && t < drop_from + drop_len);
            #0;
            if (op_req) req_cycles++;
            if (t == 1) ovf_t1 = ovf;
            if (t == 2) lm_a_t2 = L_mult_outa;
            if (t == 3) ml_a_t3 = mult_outa;
            if (t == 4) mac_c_t4 = L_mac_outc;
            if (done || err) begin
                lat = t;
                got_err = err;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, reqc, seen;
        logic gerr, o1;
        logic [15:0] lma, mla;
        logic [31:0] macc;

        reset = 1'b1; start = 1'b0; op_gnt = 1'b0; var1 = '0; var2 = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_req", 32'(op_req), 32'd0);
        reset = 1'b0; op_gnt = 1'b1;
        tick();
        chk("idle_quiet_macb", 32'(L_mac_outb), 32'd0);
        chk("idle_quiet_macc", L_mac_outc, 32'd0);

        // Basic op: hi=1, lo=2, var2=0.5
        run_op(32'h0001_0002, 16'h4000, 0, 0, lat, reqc, gerr, o1, lma, mla, macc);
        chk("t1_lat", 32'(lat), 32'd5);
        chk("t1_err", 32'(gerr), 32'd0);
        chk("t1_out", out, 32'h0000_8002);
        chk("t1_ovf", 32'(ovf), 32'd0);
        chk("t1_req_cycles", 32'(reqc), 32'd4);
        chk("t1_req_at_done", 32'(op_req), 32'd0);
        chk("t1_lmult_a", 32'(lma), 32'h0001);
        chk("t1_mult_a", 32'(mla), 32'h0002);
        chk("t1_mac_c", macc, 32'h0000_8000);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        run_op(32'h4000_0000, 16'h4000, 0, 0, lat, reqc, gerr, o1, lma, mla, macc);
        chk("t2_lat", 32'(lat), 32'd5);
        chk("t2_out", out, 32'h2000_0000);
        chk("t2_ovf", 32'(ovf), 32'd0);
        chk("t2_req_cycles", 32'(reqc), 32'd4);
        tick();

        // -1 * -1 saturates in L_mult
        run_op(32'h8000_0000, 16'h8000, 0, 0, lat, reqc, gerr, o1, lma, mla, macc);
        chk("t3_out", out, 32'h7FFF_FFFF);
        chk("t3_ovf", 32'(ovf), 32'd1);
        chk("t3_lmult_a", 32'(lma), 32'h8000);
        tick();
        chk("t3_ovf_sticky_idle", 32'(ovf), 32'd1);

        // Grant dropped for three cycles while in S_MPY
        run_op(32'h0001_0002, 16'h4000, 3, 3, lat, reqc, gerr, o1, lma, mla, macc);
        chk("t4_ovf_cleared", 32'(o1), 32'd0);
        chk("t4_lat", 32'(lat), 32'd8);
        chk("t4_out", out, 32'h0000_8002);
        chk("t4_ovf", 32'(ovf), 32'd0);
        chk("t4_req_cycles", 32'(reqc), 32'd7);
        chk("t4_mult_quiet", 32'(mla), 32'd0);
        chk("t4_mac_quiet", macc, 32'd0);
        tick();

        // Grant never arrives: abort after four request cycles
        run_op(32'h1234_5678, 16'h1111, 0, 1000, lat, reqc, gerr, o1, lma, mla, macc);
        chk("t5_err", 32'(gerr), 32'd1);
        chk("t5_lat", 32'(lat), 32'd5);
        chk("t5_req_cycles", 32'(reqc), 32'd4);
        chk("t5_req_low", 32'(op_req), 32'd0);
        chk("t5_busy_low", 32'(busy), 32'd0);
        chk("t5_out_held", out, 32'h0000_8002);
        chk("t5_quiet", 32'(lma), 32'd0);
        op_gnt = 1'b1;
        tick();
        chk("t5_err_pulse", 32'(err), 32'd0);

        // start while busy and in S_DONE is ignored
        var1 = 32'h0001_0002; var2 = 16'h4000; start = 1'b1;
        tick();
        var1 = 32'h4000_0000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) break;
            tick();
        end
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_out", out, 32'h0000_8002);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_start_in_done", 32'(busy), 32'd0);
        tick();

        // Reset while in S_MAC
        var1 = 32'h4000_0000; var2 = 16'h4000; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("t7_in_mac", 32'(L_mac_outb), 32'd1);
        reset = 1'b1;
        tick();
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_req", 32'(op_req), 32'd0);
        chk("t7_out", out, 32'd0);
        chk("t7_done", 32'(done), 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || err) seen++;
        end
        chk("t7_no_pulse", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
